mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Round-robin arbiter for the shared memory bus between cache controllers and the I/O/DMA requester (requester 0 = icache, 1 = dcache, 2 = I/O).
- Issues a one-hot grant and tracks bus ownership through each owner's busy signal.
- Inserts a one-cycle turnaround between owners and recovers from requesters that never claim a grant.
- Replaces the per-controller grant-pass daisy chain with a central scheduler.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- ID_W, 2, width of the owner index; must satisfy 2^ID_W >= NUM_REQ.
- GRANT_TIMEOUT, 15, cycles a granted requester has to assert busy before the grant is revoked; 0 disables the timeout. Counter width is 4 bits, so the maximum is 15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester bus request, level.
- busy_in  input  NUM_REQ  per-requester "bus in use"; only the current owner's bit is observed.
- grant  output  NUM_REQ  one-hot grant, registered; all zero when no grant.
- owner_id  output  ID_W  index of the current or last granted requester.
- bus_busy  output  1  high while the bus is in the OWNED state.
- bus_idle  output  1  high in the IDLE state.
- timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset: when reset_n is low at a rising edge, the block takes its reset values at that edge.
  - state = IDLE, grant = 0, owner_id = 0, bus_busy = 0, bus_idle = 1, timeout_err = 0.
  - Priority pointer ptr = 0; timeout counter = 0.
  - Applies from any state, including mid-ownership; no RELEASE cycle is generated.
- Round-robin pick: the first requester with req high, scanning ptr, ptr+1, ... NUM_REQ-1, 0, ... (mod NUM_REQ).
- States: IDLE, GRANT, OWNED, RELEASE; 2-bit encoding; all outputs registered.
- IDLE:
  - If any req is high: latch the pick into owner_id, drive grant[pick] = 1, clear the timeout counter, go to GRANT.
  - The grant is visible on the edge after req is first sampled high (latency of 1 cycle).
- GRANT:
  - grant is held.
  - If busy_in[owner_id] = 1: go to OWNED.
  - Else if req[owner_id] = 0 (abandoned request): go to RELEASE.
  - Else if GRANT_TIMEOUT != 0 and the counter reaches GRANT_TIMEOUT-1: go to RELEASE and pulse timeout_err for the RELEASE cycle.
  - Otherwise: increment the counter.
  - Priority among these conditions: busy > abandon > timeout.
- OWNED:
  - grant is held; bus_busy = 1.
  - req changes from any requester, including the owner, are ignored.
  - When busy_in[owner_id] = 0: go to RELEASE.
- RELEASE:
  - grant = 0 and bus_busy = 0 for exactly one cycle (bus turnaround).
  - ptr is set to (owner_id+1) mod NUM_REQ.
  - Arbitration uses the new ptr: if any req is high, the next state is GRANT with the new grant at the following edge; otherwise IDLE.
  - Minimum gap between two owners' grants is therefore one cycle.
- One-hot invariant: grant never has more than one bit set; grant is nonzero only in GRANT and OWNED.
- busy_in bits of non-owners and req bits of requesters with index >= NUM_REQ are ignored.
- owner_id holds its value through RELEASE and IDLE until the next grant.

Optional Feature:
- Macro: MEM_BUS_ARB_LOCK_EN.
- When defined, the block adds input `lock` (1 bit), asserted by the current owner for locked read-modify-write sequences.
  - In OWNED, when busy_in[owner_id] falls and lock = 1: the block stays granted and returns to GRANT instead of RELEASE. ptr is not advanced and the timeout counter is cleared.
  - The timeout still applies in that GRANT state.
  - lock is ignored in every state other than OWNED.
- When not defined: there is no lock port, and ownership always ends via RELEASE.

Test Plan:
- Reset, then req = 3'b010 → grant = 3'b010 one cycle later, owner_id = 1.
  - Then busy_in[1] = 1 → bus_busy = 1 on the next cycle.
  - Then busy_in[1] = 0 → one cycle with grant = 0, then IDLE.
- req = 3'b111 held; each owner asserts busy for 3 cycles and then drops it → grant sequence 001, 010, 100, 001, each separated by exactly one grant = 0 cycle.
- req[2] = 1 with busy_in[2] never asserted, GRANT_TIMEOUT = 15 → grant = 3'b100 for 15 cycles, then timeout_err pulses once and grant = 0.
- Granted requester 0 drops req before busy while req[1] = 1 → RELEASE, then grant = 3'b010 with no timeout_err.
- reset_n driven low during OWNED → at the next edge grant = 0, bus_busy = 0, bus_idle = 1, and ptr = 0 (verified by req = 3'b111 granting requester 0 first).
- With MEM_BUS_ARB_LOCK_EN: owner 1 drops busy with lock = 1 while req = 3'b111 → grant stays 3'b010 with no zero cycle; after a second busy drop with lock = 0, the next grant is 3'b100.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Central round-robin scheduler for the shared memory bus. Requester 0 is the
//   icache, 1 the dcache and 2 the I/O/DMA engine. A one-hot grant is issued,
//   ownership is tracked through the owner's busy line, a one-cycle turnaround
//   separates consecutive owners, and a grant that is never claimed is revoked
//   after GRANT_TIMEOUT cycles (0 disables the revoke).
//
//   Optional build macro: MEM_BUS_ARB_LOCK_EN adds the `lock` input, which lets
//   the owner keep the bus across a busy drop for locked read-modify-write.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   req          in   [NUM_REQ] level requests
//   busy_in      in   [NUM_REQ] bus-in-use, only the owner's bit matters
//   lock         in   (MEM_BUS_ARB_LOCK_EN only) hold ownership on busy drop
//   grant        out  [NUM_REQ] registered one-hot grant
//   owner_id     out  [ID_W] current / last granted requester
//   bus_busy     out  high in OWNED
//   bus_idle     out  high in IDLE
//   timeout_err  out  one-cycle pulse on the RELEASE after a grant timeout
module mem_bus_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ID_W          = 2,
  parameter int GRANT_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] busy_in,
`ifdef MEM_BUS_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    owner_id,
  output logic               bus_busy,
  output logic               bus_idle,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWNED   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] TMO_LAST = 4'((GRANT_TIMEOUT == 0) ? 0 : GRANT_TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [ID_W-1:0]      ptr, ptr_nxt, ptr_rel, base;
  logic [3:0]           cnt, cnt_nxt;
  logic [NUM_REQ-1:0]   grant_nxt, pick_oh, rot;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [ID_W-1:0]      owner_nxt, pick_id;
  logic                 tout_nxt, any_req, own_busy, own_req;
  int                   off, pick, rel;

  // The grant is one-hot on the owner while in GRANT/OWNED, so masking with it
  // selects the owner's bit without a variable index.
  assign own_busy = |(busy_in & grant);
  assign own_req  = |(req & grant);

  always_comb begin
    rel = int'(owner_id) + 1;
    if (rel >= NUM_REQ) rel = 0;
    ptr_rel = ID_W'(rel);
  end

  // Rotate the request vector so bit 0 is the highest-priority requester, then
  // take the lowest set bit and map it back to an absolute index.
  always_comb begin
    base    = (state == RELEASE) ? ptr_rel : ptr;
    req_dbl = {req, req} >> base;
    rot     = req_dbl[NUM_REQ-1:0];
    any_req = |rot;
    off     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    pick = int'(base) + off;
    if (pick >= NUM_REQ) pick = pick - NUM_REQ;
    pick_id = ID_W'(pick);
    pick_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_oh[i] = (i == pick);
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner_id;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    tout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          grant_nxt = pick_oh;
          owner_nxt = pick_id;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (own_busy) begin
          state_nxt = OWNED;
        end else if (!own_req) begin
          state_nxt = RELEASE;
          grant_nxt = '0;
        end else if ((GRANT_TIMEOUT != 0) && (cnt == TMO_LAST)) begin
          state_nxt = RELEASE;
          grant_nxt = '0;
          tout_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      OWNED: begin
        if (!own_busy) begin
`ifdef MEM_BUS_ARB_LOCK_EN
          if (lock) begin
            state_nxt = GRANT;
            cnt_nxt   = '0;
          end else begin
            state_nxt = RELEASE;
            grant_nxt = '0;
          end
`else
          state_nxt = RELEASE;
          grant_nxt = '0;
`endif
        end
      end
      RELEASE: begin
        ptr_nxt = ptr_rel;
        if (any_req) begin
          state_nxt = GRANT;
          grant_nxt = pick_oh;
          owner_nxt = pick_id;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      owner_id    <= '0;
      ptr         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      bus_busy    <= 1'b0;
      bus_idle    <= 1'b1;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      owner_id    <= owner_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= tout_nxt;
      bus_busy    <= (state_nxt == OWNED);
      bus_idle    <= (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter (NUM_REQ=3, ID_W=2, GRANT_TIMEOUT=15).
//   A vector table covers reset, single-owner handshake, round robin, request
//   abandon and reset during ownership; hand-written sequences cover the grant
//   timeout and, when MEM_BUS_ARB_LOCK_EN is defined, the locked hand-back.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] req;
  logic [2:0] busy_in;
  logic [2:0] grant;
  logic [1:0] owner_id;
  logic       bus_busy, bus_idle, timeout_err;
`ifdef MEM_BUS_ARB_LOCK_EN
  logic       lock;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_REQ(3), .ID_W(2), .GRANT_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .busy_in    (busy_in),
`ifdef MEM_BUS_ARB_LOCK_EN
    .lock       (lock),
`endif
    .grant      (grant),
    .owner_id   (owner_id),
    .bus_busy   (bus_busy),
    .bus_idle   (bus_idle),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic       rn;
    logic [2:0] rq;
    logic [2:0] bz;
    logic [2:0] eg;
    logic [1:0] eo;
    logic       ebb;
    logic       ebi;
    logic       eto;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rn, input logic [2:0] rq, input logic [2:0] bz,
                     input logic [2:0] eg, input logic [1:0] eo,
                     input logic ebb, input logic ebi, input logic eto);
    vec_t v;
    v.rn = rn; v.rq = rq; v.bz = bz; v.eg = eg; v.eo = eo;
    v.ebb = ebb; v.ebi = ebi; v.eto = eto;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rn, input logic [2:0] rq, input logic [2:0] bz);
    reset_n = rn;
    req     = rq;
    busy_in = bz;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] eg, input logic [1:0] eo,
                     input logic ebb, input logic ebi, input logic eto);
    logic [7:0] act, exp;
    act = {grant, owner_id, bus_busy, bus_idle, timeout_err};
    exp = {eg, eo, ebb, ebi, eto};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got grant=%b owner=%0d busy=%b idle=%b tout=%b, want grant=%b owner=%0d busy=%b idle=%b tout=%b",
               name, grant, owner_id, bus_busy, bus_idle, timeout_err, eg, eo, ebb, ebi, eto);
    end
    if ($countones(grant) > 1) begin
      failures++;
      $display("FAIL %s onehot: got grant=%b, want at most one bit set", name, grant);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    busy_in = '0;
`ifdef MEM_BUS_ARB_LOCK_EN
    lock    = 1'b0;
`endif

    //  rn  req     busy    grant   own ebb ebi eto
    add(0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 0);   // reset
    add(1, 3'b010, 3'b000, 3'b010, 1, 0, 0, 0);   // grant dcache
    add(1, 3'b010, 3'b010, 3'b010, 1, 1, 0, 0);   // owned
    add(1, 3'b010, 3'b010, 3'b010, 1, 1, 0, 0);
    add(1, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0);   // release
    add(1, 3'b000, 3'b000, 3'b000, 1, 0, 1, 0);   // idle, owner held
    add(0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 0);   // reset, ptr back to 0
    add(1, 3'b111, 3'b000, 3'b001, 0, 0, 0, 0);   // round robin: 0
    add(1, 3'b111, 3'b001, 3'b001, 0, 1, 0, 0);
    add(1, 3'b111, 3'b001, 3'b001, 0, 1, 0, 0);
    add(1, 3'b111, 3'b001, 3'b001, 0, 1, 0, 0);
    add(1, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0);   // turnaround
    add(1, 3'b111, 3'b000, 3'b010, 1, 0, 0, 0);   // 1
    add(1, 3'b111, 3'b010, 3'b010, 1, 1, 0, 0);
    add(1, 3'b111, 3'b010, 3'b010, 1, 1, 0, 0);
    add(1, 3'b111, 3'b010, 3'b010, 1, 1, 0, 0);
    add(1, 3'b111, 3'b000, 3'b000, 1, 0, 0, 0);
    add(1, 3'b111, 3'b000, 3'b100, 2, 0, 0, 0);   // 2
    add(1, 3'b111, 3'b100, 3'b100, 2, 1, 0, 0);
    add(1, 3'b111, 3'b101, 3'b100, 2, 1, 0, 0);   // non-owner busy ignored
    add(1, 3'b011, 3'b100, 3'b100, 2, 1, 0, 0);   // owner req drop ignored in OWNED
    add(1, 3'b111, 3'b000, 3'b000, 2, 0, 0, 0);
    add(1, 3'b111, 3'b000, 3'b001, 0, 0, 0, 0);   // wraps to 0
    add(1, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);   // abandon -> release
    add(1, 3'b000, 3'b000, 3'b000, 0, 0, 1, 0);   // idle, ptr=1
    add(1, 3'b001, 3'b000, 3'b001, 0, 0, 0, 0);   // only 0 requests
    add(1, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0);   // 0 abandons, no timeout
    add(1, 3'b010, 3'b000, 3'b010, 1, 0, 0, 0);   // 1 granted
    add(1, 3'b010, 3'b010, 3'b010, 1, 1, 0, 0);   // owned
    add(0, 3'b111, 3'b010, 3'b000, 0, 0, 1, 0);   // reset mid-ownership
    add(1, 3'b111, 3'b000, 3'b001, 0, 0, 0, 0);   // ptr=0 after reset
    add(1, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    add(1, 3'b000, 3'b000, 3'b000, 0, 0, 1, 0);   // idle, ptr=1

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rn, vecs[i].rq, vecs[i].bz);
      chk($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eo, vecs[i].ebb, vecs[i].ebi, vecs[i].eto);
    end

    // Timeout: requester 2 never asserts busy; grant visible for 15 cycles.
    for (int i = 0; i < 15; i++) begin
      step(1, 3'b100, 3'b000);
      chk($sformatf("tmo_hold%0d", i), 3'b100, 2, 0, 0, 0);
    end
    step(1, 3'b100, 3'b000);
    chk("tmo_revoke", 3'b000, 2, 0, 0, 1);
    step(1, 3'b100, 3'b000);
    chk("tmo_regrant", 3'b100, 2, 0, 0, 0);
    step(1, 3'b000, 3'b000);
    chk("tmo_abandon", 3'b000, 2, 0, 0, 0);
    step(1, 3'b000, 3'b000);
    chk("tmo_idle", 3'b000, 2, 0, 1, 0);

`ifdef MEM_BUS_ARB_LOCK_EN
    step(0, 3'b000, 3'b000);
    chk("lk_reset", 3'b000, 0, 0, 1, 0);
    step(1, 3'b010, 3'b000);
    chk("lk_grant", 3'b010, 1, 0, 0, 0);
    step(1, 3'b010, 3'b010);
    chk("lk_owned", 3'b010, 1, 1, 0, 0);
    lock = 1'b1;
    step(1, 3'b111, 3'b000);
    chk("lk_hold", 3'b010, 1, 0, 0, 0);
    lock = 1'b0;
    step(1, 3'b111, 3'b010);
    chk("lk_owned2", 3'b010, 1, 1, 0, 0);
    step(1, 3'b111, 3'b000);
    chk("lk_release", 3'b000, 1, 0, 0, 0);
    step(1, 3'b111, 3'b000);
    chk("lk_next", 3'b100, 2, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
